// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial ADC/SBC engine.
// Optional feature macro: ADC_DECIMAL_EN (BCD correction of ADC/SBC results).
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DEC_FIX = 2'd2,
    DONE    = 2'd3
  } adc_state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  localparam logic [7:0] BCD_LO_ADJ = 8'h06;
  localparam logic [7:0] BCD_HI_ADJ = 8'h60;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the serial ALU datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adc_unit.sv
// Bit-serial 6502 ADC/SBC engine: one operand bit pair per clock, LSB first,
// carry held in a flop between cycles. Returns result plus C/Z/N/V.
// Optional feature macro: ADC_DECIMAL_EN adds a DEC_FIX cycle for BCD mode.
//
// state   | meaning
// IDLE    | waiting for start, outputs hold last result
// SHIFT   | one bit per cycle through the full adder, WIDTH cycles
// DEC_FIX | BCD correction of the binary sum (ADC_DECIMAL_EN only)
// DONE    | one-cycle done pulse, result/flags valid
module serial_adc_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             subtract,
  input  logic             decimal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  adc_state_t       state, next_state;
  logic [WIDTH-1:0] op_a, op_b, sum_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic             cy_q;
  logic             last_bit;
  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] fin_sum, bin_sum;
  logic             fin_c, fin_v;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;

`ifdef ADC_DECIMAL_EN
  logic dec_q, sub_q, half_q, v_q;
`else
  logic unused_cfg;
  // decimal is accepted but has no effect without BCD support
  assign unused_cfg = ^{decimal, sum_sr[0]};
`endif

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (cy_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and status outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
`ifdef ADC_DECIMAL_EN
          next_state = dec_q ? DEC_FIX : DONE;
`else
          next_state = DONE;
`endif
        end
      end
      DEC_FIX: begin
        busy       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latch and serial add loop
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      sum_sr  <= '0;
      cy_q    <= 1'b0;
      bit_cnt <= '0;
`ifdef ADC_DECIMAL_EN
      dec_q   <= 1'b0;
      sub_q   <= 1'b0;
      half_q  <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a    <= a;
          op_b    <= b ^ {WIDTH{subtract}};
          cy_q    <= carry_in;
          bit_cnt <= '0;
`ifdef ADC_DECIMAL_EN
          dec_q   <= decimal;
          sub_q   <= subtract;
`endif
        end
        SHIFT: begin
          op_a    <= op_a >> 1;
          op_b    <= op_b >> 1;
          sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
          cy_q    <= fa_cout;
          bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef ADC_DECIMAL_EN
          if (bit_cnt == CNT_W'(3)) half_q <= fa_cout;
          if (last_bit)             v_q    <= cy_q ^ fa_cout;
`endif
        end
        default: ;
      endcase
    end
  end

  // Final result: taken straight off the adder on the last bit, or from the
  // completed shift register plus BCD correction in DEC_FIX
  always_comb begin
    fin_sum = {fa_sum, sum_sr[WIDTH-1:1]};
    bin_sum = fin_sum;
    fin_c   = fa_cout;
    fin_v   = cy_q ^ fa_cout;
`ifdef ADC_DECIMAL_EN
    if (state == DEC_FIX) begin
      bin_sum = sum_sr;
      fin_sum = sum_sr;
      fin_c   = cy_q;
      fin_v   = v_q;
      if (!sub_q) begin
        if ((fin_sum[3:0] > 4'd9) || half_q) fin_sum = fin_sum + BCD_LO_ADJ;
        if ((fin_sum[7:4] > 4'd9) || cy_q) begin
          fin_sum = fin_sum + BCD_HI_ADJ;
          fin_c   = 1'b1;
        end
      end else begin
        if (!half_q) fin_sum = fin_sum - BCD_LO_ADJ;
        if (!cy_q)   fin_sum = fin_sum - BCD_HI_ADJ;
      end
    end
`endif
  end

  // Result and flags update only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if ((state != DONE) && (next_state == DONE)) begin
      result_q  <= fin_sum;
      flags_q.c <= fin_c;
      flags_q.z <= (bin_sum == '0);
      flags_q.n <= bin_sum[WIDTH-1];
      flags_q.v <= fin_v;
    end
  end

  assign result    = result_q;
  assign carry_out = flags_q.c;
  assign overflow  = flags_q.v;
  assign zero      = flags_q.z;
  assign negative  = flags_q.n;

endmodule
